hub75_fb_ctrl: RTL and testbench

//   Double-buffered frame-buffer controller between the pixel writer and hub75_display.

---
 rtl/hub75_fb_ctrl.sv | 153 +++++++++++++++
 tb/tb_hub75_fb_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_fb_ctrl.sv
// ---------------------------------------------------------------------------
// hub75_fb_ctrl
//
// Double-buffered frame-buffer controller that sits between a pixel writer
// and hub75_display. A two-bank simple-dual-port pixel RAM is split so that
// the display always scans the front bank and the writer always fills the
// back bank. Banks are swapped only at a display frame boundary, so the
// panel never shows a torn image. A swap can optionally zero-fill the new
// back bank before the writer is allowed back in.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   i_disp_rd_addr    display read address (bank-local)
//   o_disp_rd_data    pixel {R,G,B} returned to the display
//   i_frame_done      1-cycle pulse: display finished the last read of a frame
//   i_wr_valid        writer pixel valid
//   o_wr_ready        controller accepts a pixel (only while idle)
//   i_wr_addr         bank-local pixel address from the writer
//   i_wr_data         pixel {R,G,B} from the writer
//   i_swap_req        1-cycle pulse: request a bank swap
//   i_swap_clear      sampled with i_swap_req: zero-fill the new back bank
//   o_swap_done       1-cycle pulse: swap (and optional clear) complete
//   o_busy            controller is not idle
//   o_front_bank      bank currently being displayed
//   o_ram_rd_addr     RAM read address {front_bank, i_disp_rd_addr}
//   i_ram_rd_data     RAM read data (1-cycle latency)
//   o_ram_wr_en       RAM write enable
//   o_ram_wr_addr     RAM write address {bank, addr}
//   o_ram_wr_data     RAM write data
// ---------------------------------------------------------------------------
module hub75_fb_ctrl #(
  parameter  int hpixel_p     = 64,
  parameter  int vpixel_p     = 64,
  parameter  int bpp_p        = 8,
  localparam int frame_size_p = hpixel_p * vpixel_p,
  localparam int addr_width_p = $clog2(frame_size_p)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [addr_width_p-1:0] i_disp_rd_addr,
  output logic [3*bpp_p-1:0]      o_disp_rd_data,
  input  logic                    i_frame_done,
  input  logic                    i_wr_valid,
  output logic                    o_wr_ready,
  input  logic [addr_width_p-1:0] i_wr_addr,
  input  logic [3*bpp_p-1:0]      i_wr_data,
  input  logic                    i_swap_req,
  input  logic                    i_swap_clear,
  output logic                    o_swap_done,
  output logic                    o_busy,
  output logic                    o_front_bank,
  output logic [addr_width_p:0]   o_ram_rd_addr,
  input  logic [3*bpp_p-1:0]      i_ram_rd_data,
  output logic                    o_ram_wr_en,
  output logic [addr_width_p:0]   o_ram_wr_addr,
  output logic [3*bpp_p-1:0]      o_ram_wr_data
);

  localparam int cnt_width_c = addr_width_p + 1;

  // The clear counter is one bit wider than a bank address so it can reach
  // frame_size_p itself, which marks "all addresses written".
  localparam logic [addr_width_p:0] frame_size_c = cnt_width_c'(frame_size_p);
  localparam logic [addr_width_p:0] cnt_one_c    = cnt_width_c'(1);

  typedef enum logic [1:0] {
    IDLE,
    SWAP_WAIT,
    CLEAR
  } state_t;

  state_t                state;
  logic                  clear_latched;
  logic [addr_width_p:0] clr_cnt;
  logic                  wr_accept;
  logic                  wr_in_range;

  // Read path is a straight pass-through so the display timing is unchanged.
  assign o_ram_rd_addr  = {o_front_bank, i_disp_rd_addr};
  assign o_disp_rd_data = i_ram_rd_data;

  assign o_wr_ready  = (state == IDLE);
  assign o_busy      = (state != IDLE);
  assign wr_accept   = i_wr_valid & o_wr_ready;
  // Non-power-of-two panels leave addresses past the frame unused; such
  // pixels are accepted to keep the writer moving, then silently dropped.
  assign wr_in_range = ({1'b0, i_wr_addr} < frame_size_c);

  // Controller FSM. All RAM-side outputs are registered here. A writer pixel
  // is captured with the back bank as it is at accept time, so a write
  // accepted together with a swap request still lands in the old back bank.
  // The front bank toggles only on i_frame_done while waiting, i.e. after
  // the display has issued its last read of the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      o_front_bank  <= 1'b0;
      clear_latched <= 1'b0;
      clr_cnt       <= '0;
      o_ram_wr_en   <= 1'b0;
      o_ram_wr_addr <= '0;
      o_ram_wr_data <= '0;
      o_swap_done   <= 1'b0;
    end else begin
      o_ram_wr_en <= 1'b0;
      o_swap_done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_accept && wr_in_range) begin
            o_ram_wr_en   <= 1'b1;
            o_ram_wr_addr <= {~o_front_bank, i_wr_addr};
            o_ram_wr_data <= i_wr_data;
          end
          if (i_swap_req) begin
            clear_latched <= i_swap_clear;
            state         <= SWAP_WAIT;
          end
        end

        SWAP_WAIT: begin
          if (i_frame_done) begin
            o_front_bank <= ~o_front_bank;
            if (clear_latched) begin
              clr_cnt <= '0;
              state   <= CLEAR;
            end else begin
              o_swap_done <= 1'b1;
              state       <= IDLE;
            end
          end
        end

        CLEAR: begin
          // front_bank already holds the new value, so ~front_bank is the
          // freshly retired bank that the writer will fill next.
          if (clr_cnt == frame_size_c) begin
            clr_cnt     <= '0;
            o_swap_done <= 1'b1;
            state       <= IDLE;
          end else begin
            o_ram_wr_en   <= 1'b1;
            o_ram_wr_addr <= {~o_front_bank, clr_cnt[addr_width_p-1:0]};
            o_ram_wr_data <= '0;
            clr_cnt       <= clr_cnt + cnt_one_c;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_fb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hub75_fb_ctrl
//
// Self-checking bench for hub75_fb_ctrl. A behavioural RAM is attached to
// the controller, and a picture-level reference model (two banks of pixels
// plus the displayed bank number) predicts what the display should see.
// A second instance built for a 60x64 panel covers out-of-range writes.
// ---------------------------------------------------------------------------
module tb_hub75_fb_ctrl;

  localparam int aw = 12;
  localparam int dw = 24;
  localparam int fs = 4096;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;

  logic [aw-1:0] disp_rd_addr = '0;
  logic [dw-1:0] disp_rd_data;
  logic          frame_done = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [aw-1:0] wr_addr = '0;
  logic [dw-1:0] wr_data = '0;
  logic          swap_req = 1'b0;
  logic          swap_clear = 1'b0;
  logic          swap_done;
  logic          busy;
  logic          front_bank;
  logic [aw:0]   ram_rd_addr;
  logic [dw-1:0] ram_rd_data = '0;
  logic          ram_wr_en;
  logic [aw:0]   ram_wr_addr;
  logic [dw-1:0] ram_wr_data;

  logic          s_wr_valid = 1'b0;
  logic [aw-1:0] s_wr_addr = '0;
  logic [dw-1:0] s_wr_data = '0;
  logic          s_wr_ready;
  logic [dw-1:0] s_disp_rd_data;
  logic          s_swap_done;
  logic          s_busy;
  logic          s_front_bank;
  logic [aw:0]   s_ram_rd_addr;
  logic          s_ram_wr_en;
  logic [aw:0]   s_ram_wr_addr;
  logic [dw-1:0] s_ram_wr_data;

  int checks = 0;
  int errors = 0;

  // Behavioural pixel RAM and the reference picture model.
  logic [dw-1:0] ram     [0:2*fs-1];
  logic [dw-1:0] ref_pic [0:1][0:fs-1];
  logic          ref_front;

  always #5 clk = ~clk;

  hub75_fb_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_disp_rd_addr (disp_rd_addr),
    .o_disp_rd_data (disp_rd_data),
    .i_frame_done   (frame_done),
    .i_wr_valid     (wr_valid),
    .o_wr_ready     (wr_ready),
    .i_wr_addr      (wr_addr),
    .i_wr_data      (wr_data),
    .i_swap_req     (swap_req),
    .i_swap_clear   (swap_clear),
    .o_swap_done    (swap_done),
    .o_busy         (busy),
    .o_front_bank   (front_bank),
    .o_ram_rd_addr  (ram_rd_addr),
    .i_ram_rd_data  (ram_rd_data),
    .o_ram_wr_en    (ram_wr_en),
    .o_ram_wr_addr  (ram_wr_addr),
    .o_ram_wr_data  (ram_wr_data)
  );

  hub75_fb_ctrl #(.hpixel_p(60), .vpixel_p(64), .bpp_p(8)) dut_small (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_disp_rd_addr ('0),
    .o_disp_rd_data (s_disp_rd_data),
    .i_frame_done   (1'b0),
    .i_wr_valid     (s_wr_valid),
    .o_wr_ready     (s_wr_ready),
    .i_wr_addr      (s_wr_addr),
    .i_wr_data      (s_wr_data),
    .i_swap_req     (1'b0),
    .i_swap_clear   (1'b0),
    .o_swap_done    (s_swap_done),
    .o_busy         (s_busy),
    .o_front_bank   (s_front_bank),
    .o_ram_rd_addr  (s_ram_rd_addr),
    .i_ram_rd_data  ('0),
    .o_ram_wr_en    (s_ram_wr_en),
    .o_ram_wr_addr  (s_ram_wr_addr),
    .o_ram_wr_data  (s_ram_wr_data)
  );

  // Simple-dual-port RAM with a registered read port.
  always @(posedge clk) begin
    if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= ram[ram_rd_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one cycle of controller inputs, then samples 1 ns after the edge.
  task automatic applyStimulus(input logic v, input logic [aw-1:0] a, input logic [dw-1:0] d,
                               input logic sr, input logic sc, input logic fd);
    wr_valid   = v;
    wr_addr    = a;
    wr_data    = d;
    swap_req   = sr;
    swap_clear = sc;
    frame_done = fd;
    @(posedge clk);
    #1;
    wr_valid   = 1'b0;
    swap_req   = 1'b0;
    frame_done = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Observes a clear in progress: counts zero writes that hit the expected
  // bank in ascending order, until o_swap_done or the budget runs out.
  task automatic waitSwapDone(input logic bank, input int budget,
                              output int nwr, output int nbad, output bit seen);
    nwr  = 0;
    nbad = 0;
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (ram_wr_en) begin
        if (ram_wr_addr !== {bank, 12'(nwr)} || ram_wr_data !== '0) nbad++;
        nwr++;
      end
      if (swap_done) begin
        seen = 1'b1;
        break;
      end
      idleCycle();
    end
  endtask

  task automatic checkDisplay(input string tag, input logic [aw-1:0] a);
    disp_rd_addr = a;
    #1;
    checkOutput({tag, "_rdaddr"}, 32'(ram_rd_addr), 32'({ref_front, a}));
    idleCycle();
    checkOutput({tag, "_pixel"}, 32'(disp_rd_data), 32'(ref_pic[ref_front][a]));
  endtask

  task automatic clearRefBank(input logic bank);
    for (int i = 0; i < fs; i++) ref_pic[bank][i] = '0;
  endtask

  initial begin
    #800000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int          nwr, nbad, pulses;
    bit          seen;
    logic        back, clr, combined;
    logic [aw-1:0] a, last_a;
    logic [dw-1:0] d;
    int          nw, waitc;

    for (int i = 0; i < 2*fs; i++) ram[i] = '0;
    clearRefBank(1'b0);
    clearRefBank(1'b1);
    ref_front = 1'b0;

    // Reset state; a valid pixel during reset must not produce a write.
    rst_n    = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = 12'd7;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_front", 32'(front_bank), 32'd0);
    checkOutput("rst_wr_en", 32'(ram_wr_en), 32'd0);
    checkOutput("rst_swap_done", 32'(swap_done), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ready", 32'(wr_ready), 32'd1);
    wr_valid = 1'b0;
    rst_n    = 1'b1;
    idleCycle();
    checkOutput("post_rst_wr_en", 32'(ram_wr_en), 32'd0);

    // Basic write into back bank 1, then a plain swap.
    $display("[TB] write and plain swap");
    checkOutput("ready_idle", 32'(wr_ready), 32'd1);
    applyStimulus(1'b1, 12'd5, 24'h112233, 1'b0, 1'b0, 1'b0);
    ref_pic[1][5] = 24'h112233;
    checkOutput("wr5_en", 32'(ram_wr_en), 32'd1);
    checkOutput("wr5_addr", 32'(ram_wr_addr), 32'h1005);
    checkOutput("wr5_data", 32'(ram_wr_data), 32'h112233);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("wait_ready", 32'(wr_ready), 32'd0);
    checkOutput("wait_busy", 32'(busy), 32'd1);
    repeat (9) idleCycle();
    checkOutput("wait_front", 32'(front_bank), 32'd0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    ref_front = 1'b1;
    checkOutput("swap1_front", 32'(front_bank), 32'd1);
    checkOutput("swap1_done", 32'(swap_done), 32'd1);
    idleCycle();
    checkOutput("swap1_done_once", 32'(swap_done), 32'd0);
    checkOutput("swap1_ready", 32'(wr_ready), 32'd1);
    checkDisplay("swap1_disp5", 12'd5);

    // Frame boundary in the same cycle as the request must not count.
    $display("[TB] same-cycle request and frame_done");
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    checkOutput("same_front", 32'(front_bank), 32'd1);
    checkOutput("same_ready", 32'(wr_ready), 32'd0);
    repeat (3) idleCycle();
    checkOutput("same_front_hold", 32'(front_bank), 32'd1);
    checkOutput("same_ready_hold", 32'(wr_ready), 32'd0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    ref_front = 1'b0;
    checkOutput("same_front_next", 32'(front_bank), 32'd0);
    checkOutput("same_done", 32'(swap_done), 32'd1);

    // Swap with clear: bank 0 becomes back and must be fully zeroed.
    $display("[TB] swap with clear");
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    repeat (3) idleCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    ref_front = 1'b1;
    clearRefBank(1'b0);
    checkOutput("clr_front", 32'(front_bank), 32'd1);
    checkOutput("clr_ready", 32'(wr_ready), 32'd0);
    waitSwapDone(1'b0, fs + 50, nwr, nbad, seen);
    checkOutput("clr_seen_done", 32'(seen), 32'd1);
    checkOutput("clr_write_count", 32'(nwr), 32'(fs));
    checkOutput("clr_bad_writes", 32'(nbad), 32'd0);
    checkOutput("clr_ready_back", 32'(wr_ready), 32'd1);
    checkDisplay("clr_disp5", 12'd5);

    // 60x64 instance: last valid address writes, past-the-frame is dropped.
    $display("[TB] out-of-range writes on 60x64 panel");
    s_wr_valid = 1'b1;
    s_wr_addr  = 12'd3839;
    s_wr_data  = 24'hA5A5A5;
    @(posedge clk);
    #1;
    checkOutput("small_in_range_en", 32'(s_ram_wr_en), 32'd1);
    checkOutput("small_in_range_addr", 32'(s_ram_wr_addr), 32'h1EFF);
    for (int k = 0; k < 2; k++) begin
      s_wr_addr = (k == 0) ? 12'd3840 : 12'd4095;
      checkOutput("small_oor_ready", 32'(s_wr_ready), 32'd1);
      @(posedge clk);
      #1;
      checkOutput("small_oor_wr_en", 32'(s_ram_wr_en), 32'd0);
    end
    s_wr_valid = 1'b0;

    // Randomized rounds of writes and swaps against the picture model.
    $display("[TB] randomized rounds");
    for (int r = 0; r < 6; r++) begin
      nw       = $urandom_range(5, 40);
      clr      = ($urandom % 3) == 0;
      combined = ($urandom % 2) == 0;
      last_a   = '0;
      for (int w = 0; w < nw; w++) begin
        logic v, fd, sr;
        v    = ($urandom % 4) != 0;
        a    = 12'($urandom % fs);
        d    = 24'($urandom);
        fd   = ($urandom % 8) == 0;
        sr   = combined && (w == nw - 1);
        back = ~ref_front;
        checkOutput("rnd_ready", 32'(wr_ready), 32'd1);
        applyStimulus(v, a, d, sr, clr, fd);
        if (v) begin
          ref_pic[back][a] = d;
          last_a = a;
          checkOutput("rnd_wr_addr", 32'(ram_wr_addr), 32'({back, a}));
          checkOutput("rnd_wr_data", 32'(ram_wr_data), 32'(d));
        end
        checkOutput("rnd_wr_en", 32'(ram_wr_en), 32'(v));
        checkOutput("rnd_front_steady", 32'(front_bank), 32'(ref_front));
      end
      if (!combined) applyStimulus(1'b0, '0, '0, 1'b1, clr, 1'b0);
      waitc = $urandom_range(0, 6);
      for (int c = 0; c < waitc; c++) begin
        applyStimulus(1'b0, '0, '0, ($urandom % 3) == 0, ~clr, 1'b0);
        checkOutput("rnd_wait_ready", 32'(wr_ready), 32'd0);
        checkOutput("rnd_wait_front", 32'(front_bank), 32'(ref_front));
      end
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      ref_front = ~ref_front;
      back      = ~ref_front;
      checkOutput("rnd_swap_front", 32'(front_bank), 32'(ref_front));
      if (clr) begin
        clearRefBank(back);
        waitSwapDone(back, fs + 50, nwr, nbad, seen);
        checkOutput("rnd_clr_seen", 32'(seen), 32'd1);
        checkOutput("rnd_clr_count", 32'(nwr), 32'(fs));
        checkOutput("rnd_clr_bad", 32'(nbad), 32'd0);
      end else begin
        checkOutput("rnd_swap_done", 32'(swap_done), 32'd1);
      end
      idleCycle();
      checkOutput("rnd_done_single", 32'(swap_done), 32'd0);
      checkDisplay("rnd_disp_last", last_a);
      for (int k = 0; k < 4; k++) begin
        a = 12'($urandom % fs);
        checkDisplay("rnd_disp", a);
        checkOutput("rnd_back_ram", 32'(ram[{back, a}]), 32'(ref_pic[back][a]));
      end
    end

    // Reset in the middle of a clear aborts it and restores bank 0.
    $display("[TB] reset during clear");
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    idleCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    repeat (100) idleCycle();
    checkOutput("midclr_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midclr_rst_front", 32'(front_bank), 32'd0);
    checkOutput("midclr_rst_busy", 32'(busy), 32'd0);
    checkOutput("midclr_rst_wr_en", 32'(ram_wr_en), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ref_front = 1'b0;
    idleCycle();
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    repeat (2) idleCycle();
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    repeat (2) idleCycle();
    checkOutput("dup_req_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    ref_front = 1'b1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      if (swap_done) pulses++;
      idleCycle();
    end
    checkOutput("dup_req_pulses", 32'(pulses), 32'd1);
    checkOutput("dup_req_front", 32'(front_bank), 32'(ref_front));
    checkOutput("dup_req_idle", 32'(busy), 32'd0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("idle_frame_done_ignored", 32'(front_bank), 32'(ref_front));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
